// File: rtl/count_monitor.sv
// Receive-side checker for an up-counter bus: locks onto +1 steps and flags value/timing faults.
// Optional sticky fault flags are built when COUNT_MONITOR_STICKY_EN is defined.
module count_monitor #(
  parameter int WIDTH  = 4,
  parameter int PERIOD = 33554432,
  parameter int TOL    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             err_seq,
  output logic             err_early,
  output logic             err_timeout,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] last_value,
  output logic [1:0]       dbg_state
`ifdef COUNT_MONITOR_STICKY_EN
  ,
  input  logic             clr_sticky,
  output logic [2:0]       sticky_err
`endif
);

  localparam int TMAX = PERIOD + TOL;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TMAX);
  localparam logic [TW-1:0] T_MIN = TW'(PERIOD - TOL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [TW-1:0]    r_timer;
  logic             r_locked;
  logic             r_err_seq;
  logic             r_err_early;
  logic             r_err_timeout;
  logic [7:0]       r_err_count;

  logic [WIDTH-1:0] w_s2_inc;
  logic             w_chg;
  logic             w_step_ok;
  logic             w_early;
  logic [TW-1:0]    w_timer_next;
  logic [7:0]       w_count_inc;

  // r_timer holds the cycles since the last change, so in a change cycle it is the step interval.
  assign w_s2_inc     = r_s2 + WIDTH'(1);
  assign w_chg        = (r_s1 != r_s2);
  assign w_step_ok    = (r_s1 == w_s2_inc);
  assign w_early      = (r_timer < T_MIN);
  assign w_timer_next = w_chg ? '0 : ((r_timer == T_MAX) ? r_timer : r_timer + TW'(1));
  assign w_count_inc  = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_s1          <= '0;
      r_s2          <= '0;
      r_timer       <= '0;
      r_locked      <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_count   <= 8'd0;
    end else begin
      r_s1          <= count_in;
      r_s2          <= r_s1;
      r_err_seq     <= 1'b0;
      r_err_early   <= 1'b0;
      r_err_timeout <= 1'b0;
      if (!enable) begin
        r_state  <= ST_IDLE;
        r_locked <= 1'b0;
        r_timer  <= '0;
      end else begin
        r_timer <= w_timer_next;
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_SYNC;
            r_timer <= '0;
          end
          ST_SYNC: begin
            if (w_chg && w_step_ok) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end
          end
          ST_LOCKED: begin
            // A bad value outranks a bad interval; a step at the saturated timer is still legal.
            if (w_chg && !w_step_ok) begin
              r_err_seq   <= 1'b1;
              r_err_count <= w_count_inc;
              r_state     <= ST_SYNC;
              r_locked    <= 1'b0;
            end else if (w_chg && w_early) begin
              r_err_early <= 1'b1;
              r_err_count <= w_count_inc;
              r_state     <= ST_SYNC;
              r_locked    <= 1'b0;
            end else if (!w_chg && (r_timer == T_MAX)) begin
              r_err_timeout <= 1'b1;
              r_err_count   <= w_count_inc;
              r_state       <= ST_SYNC;
              r_locked      <= 1'b0;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef COUNT_MONITOR_STICKY_EN
  logic [2:0] r_sticky;

  // Latched from the pulse registers; a new fault wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 3'b000;
    end else begin
      r_sticky <= (r_sticky & ~{3{clr_sticky}}) | {r_err_timeout, r_err_early, r_err_seq};
    end
  end

  assign sticky_err = r_sticky;
`endif

  assign locked      = r_locked;
  assign err_seq     = r_err_seq;
  assign err_early   = r_err_early;
  assign err_timeout = r_err_timeout;
  assign err_count   = r_err_count;
  assign last_value  = r_s2;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor with PERIOD=16, TOL=2: step table, timeout/enable/saturation/reset sequences.
module tb_count_monitor;
  localparam int WIDTH  = 4;
  localparam int PERIOD = 16;
  localparam int TOL    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [WIDTH-1:0] count_in;
  logic             locked;
  logic             err_seq;
  logic             err_early;
  logic             err_timeout;
  logic [7:0]       err_count;
  logic [WIDTH-1:0] last_value;
  logic [1:0]       dbg_state;
`ifdef COUNT_MONITOR_STICKY_EN
  logic             clr_sticky;
  logic [2:0]       sticky_err;
`endif

  count_monitor #(.WIDTH(WIDTH), .PERIOD(PERIOD), .TOL(TOL)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .count_in(count_in),
    .locked(locked),
    .err_seq(err_seq),
    .err_early(err_early),
    .err_timeout(err_timeout),
    .err_count(err_count),
    .last_value(last_value),
    .dbg_state(dbg_state)
`ifdef COUNT_MONITOR_STICKY_EN
    ,
    .clr_sticky(clr_sticky),
    .sticky_err(sticky_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ival;
    logic [3:0] val;
    logic       l;
    logic       s;
    logic       e;
    logic       t;
    logic [7:0] c;
  } step_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          since   = 0;
  logic [15:0] exp_q[$];
  step_t       tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
    since++;
  endtask

  function automatic logic [15:0] pk(input logic l, input logic s, input logic e, input logic t,
                                     input logic [7:0] c, input logic [3:0] v);
    return {l, s, e, t, c, v};
  endfunction

  function automatic step_t mk(input int ival, input logic [3:0] val, input logic l, input logic s,
                               input logic e, input logic t, input logic [7:0] c);
    step_t r;
    r.ival = ival; r.val = val; r.l = l; r.s = s; r.e = e; r.t = t; r.c = c;
    return r;
  endfunction

  task automatic expect_out(input logic [15:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name);
    logic [15:0] e;
    logic [15:0] got;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e   = exp_q.pop_front();
    got = {locked, err_seq, err_early, err_timeout, err_count, last_value};
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got lock=%b seq=%b early=%b to=%b cnt=%0d last=%h, expected lock=%b seq=%b early=%b to=%b cnt=%0d last=%h",
               name, got[15], got[14], got[13], got[12], got[11:4], got[3:0],
               e[15], e[14], e[13], e[12], e[11:4], e[3:0]);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // The change is driven so that the monitor sees it with timer == ival (gap of ival+1 cycles).
  task automatic apply_step(input step_t s, input string name);
    int w;
    w = s.ival + 1 - since;
    for (int k = 0; k < w; k++) tick();
    count_in = s.val;
    since    = 0;
    expect_out(pk(s.l, s.s, s.e, s.t, s.c, s.val));
    tick();
    tick();
    check(name);
    expect_out(pk(s.l, 1'b0, 1'b0, 1'b0, s.c, s.val));
    tick();
    check({name, "_hold"});
  endtask

  initial begin
    logic [3:0] v;
    logic [7:0] c;
    rst      = 1'b1;
    enable   = 1'b0;
    count_in = 4'h0;
`ifdef COUNT_MONITOR_STICKY_EN
    clr_sticky = 1'b0;
`endif
    tick();
    tick();
    expect_out(pk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0));
    check("reset");
    check_val("reset_state", int'(dbg_state), 0);
    rst    = 1'b0;
    enable = 1'b1;
    since  = 0;

    for (int i = 1; i < 16; i++) tbl.push_back(mk(15, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(15, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
    for (int i = 1; i < 6; i++) tbl.push_back(mk(15, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(15, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(15, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(14, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(18, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(16, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(17, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(13, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2));
    tbl.push_back(mk(5,  4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2));
    tbl.push_back(mk(3,  4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3));
    tbl.push_back(mk(15, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3));
    tbl.push_back(mk(18, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3));
    for (int i = 0; i < tbl.size(); i++) apply_step(tbl[i], $sformatf("step%0d", i));
    check_val("state_locked", int'(dbg_state), 2);

    // Frozen count: timer saturates at 18 and the timeout pulse follows one edge later.
    while (since < 20) tick();
    expect_out(pk(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 4'h2));
    check("timeout_before");
    tick();
    expect_out(pk(1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 4'h2));
    check("timeout_pulse");
    tick();
    expect_out(pk(1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 4'h2));
    check("timeout_hold");
    apply_step(mk(0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4), "relock_after_timeout");

    enable = 1'b0;
    tick();
    expect_out(pk(1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 4'h3));
    check("disable_unlock");
    count_in = 4'h9;
    tick();
    tick();
    expect_out(pk(1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 4'h9));
    check("disable_no_err");
    check_val("state_idle", int'(dbg_state), 0);
    enable = 1'b1;
    tick();
    apply_step(mk(0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4), "relock_after_enable");

    v = 4'hA;
    for (int i = 0; i < 260; i++) begin
      c = (5 + i > 255) ? 8'hFF : 8'(5 + i);
      v = v + 4'd2;
      count_in = v;
      expect_out(pk(1'b0, 1'b1, 1'b0, 1'b0, c, v));
      tick();
      tick();
      check($sformatf("sat_seq%0d", i));
      v = v + 4'd1;
      count_in = v;
      tick();
      tick();
    end
    expect_out(pk(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, v));
    check("sat_final");

    rst = 1'b1;
    tick();
    expect_out(pk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0));
    check("reset_mid_run");
    check_val("reset_mid_state", int'(dbg_state), 0);
    count_in = 4'h0;
    tick();
    rst   = 1'b0;
    since = 0;

`ifdef COUNT_MONITOR_STICKY_EN
    check_val("sticky_reset", int'(sticky_err), 0);
    apply_step(mk(4, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0), "st_lock");
    apply_step(mk(4, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1), "st_seq");
    check_val("sticky_seq", int'(sticky_err), 1);
    apply_step(mk(0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1), "st_relock");
    while (since < 21) tick();
    expect_out(pk(1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 4'h4));
    check("st_timeout");
    tick();
    check_val("sticky_seq_timeout", int'(sticky_err), 5);
    apply_step(mk(0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2), "st_relock2");
    count_in = 4'h6;
    since    = 0;
    tick();
    tick();
    expect_out(pk(1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 4'h6));
    check("st_early");
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check_val("sticky_clr_vs_set", int'(sticky_err), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
